// File: rtl/avalon_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : avalon_arb_pkg
//  Purpose  : Shared types for the two-port Avalon-MM DRAM arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package avalon_arb_pkg;

    localparam int REQ_ID_W = 1;
    localparam int BURST_W  = 7;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        WR_BURST = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [REQ_ID_W-1:0] id;
        logic [BURST_W-1:0]  burst_cnt;
    } rd_tag_struct;

endpackage
`default_nettype wire

// File: rtl/avalon_rd_tag_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : avalon_rd_tag_fifo
//  Purpose  : Outstanding-read tag FIFO; records issuing requester and burst
//             length so read beats can be steered back in order.
//  Revision : 1.0 - initial release
// ============================================================================
module avalon_rd_tag_fifo
    import avalon_arb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  rd_tag_struct din_i,
    input  logic         pop_i,
    output rd_tag_struct dout_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;
    rd_tag_struct mem_q [DEPTH];
    logic         w_push;
    logic         w_pop;

    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;
    // Extra MSB distinguishes full from empty when the index bits match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule
`default_nettype wire

// File: rtl/avalon_dram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : avalon_dram_port_arbiter
//  Purpose  : Round-robin sharing of one Avalon-MM DRAM port between two
//             requesters, with write-burst locking and in-order read steering.
//  Revision : 1.0 - initial release
// ============================================================================
module avalon_dram_port_arbiter
    import avalon_arb_pkg::*;
#(
    parameter int mem_addr_w_p    = 32,
    parameter int mem_data_w_p    = 64,
    parameter int mem_wr_mask_w_p = mem_data_w_p >> 3,
    parameter int MAX_OUTST_RD    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req0_mem_read_en,
    input  logic                       req0_mem_write_en,
    input  logic [mem_addr_w_p-1:0]    req0_mem_addr,
    input  logic [mem_data_w_p-1:0]    req0_mem_wr_data,
    input  logic [mem_wr_mask_w_p-1:0] req0_mem_byte_en,
    input  logic [BURST_W-1:0]         req0_mem_burst_cnt,
    output logic                       mem_req0_rdy,
    output logic                       mem_req0_rd_data_val,
    output logic [mem_data_w_p-1:0]    mem_req0_rd_data,
    input  logic                       req1_mem_read_en,
    input  logic                       req1_mem_write_en,
    input  logic [mem_addr_w_p-1:0]    req1_mem_addr,
    input  logic [mem_data_w_p-1:0]    req1_mem_wr_data,
    input  logic [mem_wr_mask_w_p-1:0] req1_mem_byte_en,
    input  logic [BURST_W-1:0]         req1_mem_burst_cnt,
    output logic                       mem_req1_rdy,
    output logic                       mem_req1_rd_data_val,
    output logic [mem_data_w_p-1:0]    mem_req1_rd_data,
    output logic                       arb_mem_read_en,
    output logic                       arb_mem_write_en,
    output logic [mem_addr_w_p-1:0]    arb_mem_addr,
    output logic [mem_data_w_p-1:0]    arb_mem_wr_data,
    output logic [mem_wr_mask_w_p-1:0] arb_mem_byte_en,
    output logic [BURST_W-1:0]         arb_mem_burst_cnt,
    input  logic                       mem_arb_rdy,
    input  logic                       mem_arb_rd_data_val,
    input  logic [mem_data_w_p-1:0]    mem_arb_rd_data
);

    arb_state_e           state_q, state_d;
    logic                 owner_q, owner_d;
    logic                 rr_q, rr_d;
    logic [BURST_W-1:0]   wr_left_q, wr_left_d;
    logic [BURST_W-1:0]   rd_cnt_q, rd_cnt_d;

    logic [1:0]           w_rd, w_wr, w_elig;
    logic                 w_gnt, w_gnt_vld, w_accept, w_beat;
    logic                 w_full, w_empty, w_push, w_pop;
    rd_tag_struct         w_tag_din, w_tag_head;

    logic                       w_sel_rd, w_sel_wr;
    logic [mem_addr_w_p-1:0]    w_sel_addr;
    logic [mem_data_w_p-1:0]    w_sel_wdata;
    logic [mem_wr_mask_w_p-1:0] w_sel_be;
    logic [BURST_W-1:0]         w_sel_burst;

    assign w_rd   = {req1_mem_read_en,  req0_mem_read_en};
    assign w_wr   = {req1_mem_write_en, req0_mem_write_en};
    assign w_elig = w_wr | (w_rd & {2{~w_full}});

    always_comb begin
        w_gnt     = 1'b0;
        w_gnt_vld = 1'b0;
        case (state_q)
            IDLE: begin
                w_gnt     = (&w_elig) ? rr_q : w_elig[1];
                w_gnt_vld = |w_elig;
            end
            HOLD: begin
                w_gnt     = owner_q;
                w_gnt_vld = w_rd[owner_q] | w_wr[owner_q];
            end
            WR_BURST: begin
                w_gnt     = owner_q;
                w_gnt_vld = w_wr[owner_q];
            end
            default: ;
        endcase
    end

    assign w_sel_rd    = w_gnt ? req1_mem_read_en   : req0_mem_read_en;
    assign w_sel_wr    = w_gnt ? req1_mem_write_en  : req0_mem_write_en;
    assign w_sel_addr  = w_gnt ? req1_mem_addr      : req0_mem_addr;
    assign w_sel_wdata = w_gnt ? req1_mem_wr_data   : req0_mem_wr_data;
    assign w_sel_be    = w_gnt ? req1_mem_byte_en   : req0_mem_byte_en;
    assign w_sel_burst = w_gnt ? req1_mem_burst_cnt : req0_mem_burst_cnt;

    assign arb_mem_read_en   = w_gnt_vld & w_sel_rd;
    assign arb_mem_write_en  = w_gnt_vld & w_sel_wr;
    assign arb_mem_addr      = w_gnt_vld ? w_sel_addr  : '0;
    assign arb_mem_wr_data   = w_gnt_vld ? w_sel_wdata : '0;
    assign arb_mem_byte_en   = w_gnt_vld ? w_sel_be    : '0;
    assign arb_mem_burst_cnt = w_gnt_vld ? w_sel_burst : '0;

    assign w_accept     = w_gnt_vld & mem_arb_rdy;
    assign mem_req0_rdy = w_accept & ~w_gnt;
    assign mem_req1_rdy = w_accept &  w_gnt;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        wr_left_d = wr_left_q;
        w_push    = 1'b0;
        case (state_q)
            IDLE, HOLD: begin
                if (!w_gnt_vld) begin
                    state_d = IDLE;
                end else if (!w_accept) begin
                    // Command must stay on the bus unchanged under waitrequest.
                    state_d = HOLD;
                    owner_d = w_gnt;
                end else begin
                    state_d = IDLE;
                    if (w_sel_rd) begin
                        w_push = 1'b1;
                        rr_d   = ~w_gnt;
                    end else if (w_sel_burst == 7'd1) begin
                        rr_d = ~w_gnt;
                    end else begin
                        wr_left_d = w_sel_burst - 7'd1;
                        owner_d   = w_gnt;
                        state_d   = WR_BURST;
                    end
                end
            end
            WR_BURST: begin
                if (w_accept) begin
                    wr_left_d = wr_left_q - 7'd1;
                    if (wr_left_q == 7'd1) begin
                        rr_d    = ~owner_q;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign w_tag_din.id        = w_gnt;
    assign w_tag_din.burst_cnt = w_sel_burst;

    // Beats arriving with no outstanding tag have no owner and are dropped.
    assign w_beat = mem_arb_rd_data_val & ~w_empty;
    assign w_pop  = w_beat && ((rd_cnt_q + 7'd1) == w_tag_head.burst_cnt);

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        if (w_beat) rd_cnt_d = w_pop ? 7'd0 : rd_cnt_q + 7'd1;
    end

    assign mem_req0_rd_data_val = w_beat & (w_tag_head.id == 1'b0);
    assign mem_req1_rd_data_val = w_beat & (w_tag_head.id == 1'b1);
    assign mem_req0_rd_data     = mem_arb_rd_data;
    assign mem_req1_rd_data     = mem_arb_rd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            rr_q      <= 1'b0;
            wr_left_q <= '0;
            rd_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            wr_left_q <= wr_left_d;
            rd_cnt_q  <= rd_cnt_d;
        end
    end

    avalon_rd_tag_fifo #(
        .DEPTH (MAX_OUTST_RD)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .din_i   (w_tag_din),
        .pop_i   (w_pop),
        .dout_o  (w_tag_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

`ifndef SYNTHESIS
    a_rw_excl0: assert property (@(posedge clk) disable iff (rst)
        !(req0_mem_read_en && req0_mem_write_en))
        else $error("req0 read_en and write_en together");
    a_rw_excl1: assert property (@(posedge clk) disable iff (rst)
        !(req1_mem_read_en && req1_mem_write_en))
        else $error("req1 read_en and write_en together");
    a_burst0: assert property (@(posedge clk) disable iff (rst)
        !((req0_mem_read_en || req0_mem_write_en) && req0_mem_burst_cnt == 7'd0))
        else $error("req0 burst_cnt of zero");
    a_burst1: assert property (@(posedge clk) disable iff (rst)
        !((req1_mem_read_en || req1_mem_write_en) && req1_mem_burst_cnt == 7'd0))
        else $error("req1 burst_cnt of zero");
    a_owner_rd: assert property (@(posedge clk) disable iff (rst)
        !(state_q == WR_BURST && w_rd[owner_q]))
        else $error("burst owner issued a read mid write burst");
    a_rd_empty: assert property (@(posedge clk) disable iff (rst)
        !(mem_arb_rd_data_val && w_empty))
        else $error("read data with no outstanding read");
`endif

endmodule
`default_nettype wire
